rdat_frame_arbiter: RTL and testbench
=====================================

// Module: rdat_frame_arbiter
// PURPOSE
//  Captures 3WI read-data (RDAT) frames from up to 8 ASC channels into per-channel shadow registers.
//  Round-robin serialises newly captured frames onto a single valid/ready stream for the 3WI host logic.
//  Keeps a registered mirror of the latest frame per channel and flags frames lost to overwrite.
//  Generalises the fixed 8-channel, register-only RDAT stage: parametrised width and channel count, plus arbitration and overflow tracking.
// PARAMETERS
//  CH_COUNT   8    number of ASC channels, legal 1..8
//  FRAME_W    70   RDAT frame width in bits (52 for ASC1..7-style frames)
//  CH_IDX_W   3    width of out_ch; must satisfy 2**CH_IDX_W >= CH_COUNT
// PORTS
//  clk_3wi      in   1                  3WI clock; all logic on rising edge
//  rst_3wi      in   1                  synchronous, active-high reset
//  frame_in     in   CH_COUNT*FRAME_W   channel i frame at [i*FRAME_W +: FRAME_W]
//  frame_vld    in   CH_COUNT           1-cycle strobe: frame_in slice i is valid this cycle
//  rdat_mirror  out  CH_COUNT*FRAME_W   latest captured frame per channel (shadow registers)
//  out_frame    out  FRAME_W            presented frame
//  out_ch       out  CH_IDX_W           channel index of out_frame
//  out_vld      out  1                  out_frame/out_ch valid
//  out_rdy      in   1                  consumer accepts when out_vld & out_rdy
//  ovf_sticky   out  CH_COUNT           bit i set: a pending channel-i frame was overwritten before being presented
//  ovf_clr      in   CH_COUNT           bit i clears ovf_sticky[i]
// BEHAVIOUR
//  Reset (rst_3wi=1 at an edge): shadow/rdat_mirror=0, pend=0, ovf_sticky=0, out_frame=0, out_ch=0,
//   out_vld=0, rr_ptr=0, state=IDLE. Reset mid-presentation drops the frame; no acceptance is reported.
//  Capture: frame_vld[i] at edge t -> shadow[i]<=slice, pend[i]<=1; visible on rdat_mirror at t+1.
//  Overflow: frame_vld[i] while pend[i]=1 -> shadow overwritten (latest wins), ovf_sticky[i]<=1.
//   Same-cycle ovf_clr[i] and overflow set -> set wins.
//  Arbiter FSM, two states:
//   IDLE: if any pend, sel = first pending index scanning rr_ptr, rr_ptr+1, ... wrapping CH_COUNT-1 -> 0.
//    Load out_frame<=shadow[sel], out_ch<=sel, out_vld<=1, pend[sel]<=0, go PRESENT.
//    If frame_vld[sel] in that same cycle: shadow updated and pend[sel] stays 1 (no overflow flagged).
//   PRESENT: out_frame/out_ch/out_vld held stable regardless of shadow updates.
//    On out_vld & out_rdy: out_vld<=0, rr_ptr<=(sel==CH_COUNT-1)?0:sel+1, go IDLE.
//  Latency: frame_vld at t (FSM idle, no other pend) -> out_vld=1 at t+2. Peak rate: 1 frame per 2 cycles.
//  Fairness: a continuously pending channel waits at most CH_COUNT-1 grants.
//  out_rdy is ignored when out_vld=0; out_rdy may be held high permanently.
// CONFIGURATION
//  RDAT_CHANGE_ONLY_EN defined: frame_vld[i] whose data equals shadow[i] is dropped (no shadow write,
//   no pend, no overflow), except the first frame per channel after reset, which always pends
//   (tracked by a per-channel seen bit cleared by reset).
//  Not defined: every frame_vld strobe captures and pends, identical data included.
// TESTING
//  Reset: assert rst_3wi 2 cycles with frame_vld=all 1s -> all outputs 0, no out_vld for 3 cycles after release.
//  Single: frame_vld[2] with 70'h3_0000_0000_0000_ABCD, out_rdy=1 -> rdat_mirror ch2 at t+1, out_vld t+2 with out_ch=2, frame 70'h3_..._ABCD.
//  Round robin: frame_vld=8'hFF same cycle, out_rdy=1 -> out_ch order 0,1,...,7, one grant every 2 cycles.
//  Backpressure/overflow: ch5 frame A, out_rdy=0; ch5 frame B, then C -> out holds A; ovf_sticky[5]=1; after accept, next out is C; ovf_clr[5] clears.
//  Set-vs-clear: ovf_clr[1]=1 same cycle as overflow on ch1 -> ovf_sticky[1]=1.
//  RDAT_CHANGE_ONLY_EN: ch0 sends 70'h5 three times -> exactly one out_vld; 70'h6 -> second; without macro -> four.

Source files
------------

// File: rtl/rdat_frame_arbiter_if.sv
// Presented-frame stream of the RDAT arbiter: frame, channel, valid/ready.
// master drives out_frame/out_ch/out_vld and samples out_rdy; slave is the consumer.
interface rdat_frame_arbiter_if #(
    parameter int FRAME_W  = 70,
    parameter int CH_IDX_W = 3
);
    logic [FRAME_W-1:0]  out_frame;
    logic [CH_IDX_W-1:0] out_ch;
    logic                out_vld;
    logic                out_rdy;

    modport master (
        output out_frame,
        output out_ch,
        output out_vld,
        input  out_rdy
    );

    modport slave (
        input  out_frame,
        input  out_ch,
        input  out_vld,
        output out_rdy
    );
endinterface

// File: rtl/rdat_frame_arbiter.sv
// RDAT frame capture into per-channel shadows, round-robin onto one stream.
// Ports: clk_3wi, rst_3wi (sync, high), frame_in/frame_vld (capture),
//   rdat_mirror (shadows), out_if (master: out_frame/out_ch/out_vld/out_rdy),
//   ovf_sticky/ovf_clr (lost-frame flags).
// Option macro RDAT_CHANGE_ONLY_EN: drop frames equal to the shadow after
//   the first frame per channel.
module rdat_frame_arbiter #(
    parameter int CH_COUNT = 8,
    parameter int FRAME_W  = 70,
    parameter int CH_IDX_W = 3
) (
    input  logic                         clk_3wi,
    input  logic                         rst_3wi,
    input  logic [CH_COUNT*FRAME_W-1:0]  frame_in,
    input  logic [CH_COUNT-1:0]          frame_vld,
    output logic [CH_COUNT*FRAME_W-1:0]  rdat_mirror,
    rdat_frame_arbiter_if.master         out_if,
    output logic [CH_COUNT-1:0]          ovf_sticky,
    input  logic [CH_COUNT-1:0]          ovf_clr
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [FRAME_W-1:0]  shadow_q [CH_COUNT];
    logic [CH_COUNT-1:0] pend_q, pend_d;
    logic [CH_COUNT-1:0] ovf_q, ovf_d;
    logic [CH_COUNT-1:0] cap;
    logic [CH_COUNT-1:0] grant;
    logic [CH_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_IDX_W-1:0] sel;
    logic                any_pend;
    logic                load;
    logic                accept;

    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [CH_IDX_W-1:0] ch_q, ch_d;
    logic                vld_q, vld_d;

`ifdef RDAT_CHANGE_ONLY_EN
    logic [CH_COUNT-1:0] seen_q;
`endif

    // Forward scan from rr_ptr realised as a reverse loop: the last hit
    // written is the first pending channel in round-robin order.
    always_comb begin
        logic [CH_IDX_W:0] idx;
        idx      = '0;
        sel      = '0;
        any_pend = 1'b0;
        for (int k = CH_COUNT - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (CH_IDX_W + 1)'(k);
            if (idx >= (CH_IDX_W + 1)'(CH_COUNT)) begin
                idx = idx - (CH_IDX_W + 1)'(CH_COUNT);
            end
            if (pend_q[idx[CH_IDX_W-1:0]]) begin
                sel      = idx[CH_IDX_W-1:0];
                any_pend = 1'b1;
            end
        end
    end

    always_comb begin
        cap = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
`ifdef RDAT_CHANGE_ONLY_EN
            cap[i] = frame_vld[i] &
                     (~seen_q[i] |
                      (frame_in[i*FRAME_W +: FRAME_W] != shadow_q[i]));
`else
            cap[i] = frame_vld[i];
`endif
        end
    end

    assign load   = (state_q == IDLE) & any_pend;
    assign accept = vld_q & out_if.out_rdy;
    assign grant  = load ? (CH_COUNT'(1) << sel) : '0;

    // A capture on the channel being granted refills pend without counting
    // as a loss; the granted frame is the pre-capture shadow.
    assign pend_d = (pend_q & ~grant) | cap;
    assign ovf_d  = (ovf_q & ~ovf_clr) | (cap & pend_q & ~grant);

    always_ff @(posedge clk_3wi) begin
        if (rst_3wi) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_pend) state_d = PRESENT;
            PRESENT: if (accept)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_d  = frame_q;
        ch_d     = ch_q;
        vld_d    = vld_q;
        rr_ptr_d = rr_ptr_q;
        unique case (1'b1)
            load: begin
                frame_d = shadow_q[sel];
                ch_d    = sel;
                vld_d   = 1'b1;
            end
            accept: begin
                vld_d    = 1'b0;
                rr_ptr_d = (ch_q == CH_IDX_W'(CH_COUNT - 1)) ? '0
                                                             : ch_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_3wi) begin
        if (rst_3wi) begin
            for (int i = 0; i < CH_COUNT; i++) begin
                shadow_q[i] <= '0;
            end
            pend_q   <= '0;
            ovf_q    <= '0;
            rr_ptr_q <= '0;
            frame_q  <= '0;
            ch_q     <= '0;
            vld_q    <= 1'b0;
        end else begin
            for (int i = 0; i < CH_COUNT; i++) begin
                if (cap[i]) begin
                    shadow_q[i] <= frame_in[i*FRAME_W +: FRAME_W];
                end
            end
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            rr_ptr_q <= rr_ptr_d;
            frame_q  <= frame_d;
            ch_q     <= ch_d;
            vld_q    <= vld_d;
        end
    end

`ifdef RDAT_CHANGE_ONLY_EN
    always_ff @(posedge clk_3wi) begin
        if (rst_3wi) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_q | cap;
        end
    end
`endif

    for (genvar g = 0; g < CH_COUNT; g++) begin : g_mirror
        assign rdat_mirror[g*FRAME_W +: FRAME_W] = shadow_q[g];
    end

    assign ovf_sticky       = ovf_q;
    assign out_if.out_frame = frame_q;
    assign out_if.out_ch    = ch_q;
    assign out_if.out_vld   = vld_q;

endmodule

// File: tb/tb_rdat_frame_arbiter.sv
// Directed bench for rdat_frame_arbiter with a per-cycle reference model.
// Honours RDAT_CHANGE_ONLY_EN when defined for the build.
module tb_rdat_frame_arbiter;

    localparam int CH = 8;
    localparam int FW = 70;

    logic            clk_3wi = 1'b0;
    logic            rst_3wi;
    logic [CH*FW-1:0] frame_in;
    logic [CH-1:0]   frame_vld;
    logic [CH*FW-1:0] rdat_mirror;
    logic [CH-1:0]   ovf_sticky;
    logic [CH-1:0]   ovf_clr;
    logic            out_rdy;

    rdat_frame_arbiter_if #(.FRAME_W(FW), .CH_IDX_W(3)) oif ();
    assign oif.out_rdy = out_rdy;

    rdat_frame_arbiter #(
        .CH_COUNT(CH),
        .FRAME_W (FW),
        .CH_IDX_W(3)
    ) dut (
        .clk_3wi    (clk_3wi),
        .rst_3wi    (rst_3wi),
        .frame_in   (frame_in),
        .frame_vld  (frame_vld),
        .rdat_mirror(rdat_mirror),
        .out_if     (oif),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk_3wi = ~clk_3wi;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Reference model: pending set, latest-frame store, one presentation slot.
    logic [FW-1:0] m_sh [CH];
    bit [CH-1:0]   m_pend = '0;
    bit [CH-1:0]   m_ovf  = '0;
    bit [CH-1:0]   m_seen = '0;
    bit            m_vld  = 1'b0;
    int            m_ch   = 0;
    logic [FW-1:0] m_frame = '0;
    int            m_ptr  = 0;

    initial begin
        for (int i = 0; i < CH; i++) m_sh[i] = '0;
    end

    function automatic bit takes(input int i, input logic [FW-1:0] d);
`ifdef RDAT_CHANGE_ONLY_EN
        return !m_seen[i] || (d != m_sh[i]);
`else
        return (i >= 0) || (d == d);
`endif
    endfunction

    always @(posedge clk_3wi) begin : model
        bit [CH-1:0]   old_pend;
        int            g;
        bit            acc;
        logic [FW-1:0] sl;
        if (rst_3wi) begin
            for (int i = 0; i < CH; i++) m_sh[i] = '0;
            m_pend = '0; m_ovf = '0; m_seen = '0;
            m_vld = 1'b0; m_ch = 0; m_frame = '0; m_ptr = 0;
        end else begin
            old_pend = m_pend;
            acc = m_vld && out_rdy;
            g = -1;
            if (!m_vld) begin
                for (int k = 0; k < CH; k++) begin
                    if (g < 0 && m_pend[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
                end
            end
            if (g >= 0) begin
                m_frame = m_sh[g];
                m_ch = g;
                m_vld = 1'b1;
                m_pend[g] = 1'b0;
            end else if (acc) begin
                m_vld = 1'b0;
                m_ptr = (m_ch + 1) % CH;
            end
            for (int i = 0; i < CH; i++) begin
                sl = frame_in[i*FW +: FW];
                if (ovf_clr[i]) m_ovf[i] = 1'b0;
                if (frame_vld[i] && takes(i, sl)) begin
                    if (old_pend[i] && i != g) m_ovf[i] = 1'b1;
                    m_sh[i] = sl;
                    m_pend[i] = 1'b1;
                    m_seen[i] = 1'b1;
                end
            end
        end
    end

    int            hs_ch [$];
    logic [FW-1:0] hs_fr [$];
    int            hs_cyc [$];
    int            vld_cycles = 0;

    always @(negedge clk_3wi) begin : compare
        logic [CH*FW-1:0] m_mir;
        bit bad;
        cyc++;
        for (int i = 0; i < CH; i++) m_mir[i*FW +: FW] = m_sh[i];
        bad = 1'b0;
        vecs++;
        if (oif.out_vld !== m_vld) begin
            bad = 1'b1;
            $display("FAIL cyc%0d out_vld: got %b want %b", cyc, oif.out_vld, m_vld);
        end
        if (m_vld && (int'(oif.out_ch) != m_ch || oif.out_frame !== m_frame)) begin
            bad = 1'b1;
            $display("FAIL cyc%0d out: got ch%0d %h want ch%0d %h",
                     cyc, oif.out_ch, oif.out_frame, m_ch, m_frame);
        end
        if (rdat_mirror !== m_mir) begin
            bad = 1'b1;
            $display("FAIL cyc%0d rdat_mirror: got %h want %h", cyc, rdat_mirror, m_mir);
        end
        if (ovf_sticky !== m_ovf) begin
            bad = 1'b1;
            $display("FAIL cyc%0d ovf_sticky: got %b want %b", cyc, ovf_sticky, m_ovf);
        end
        if (bad) errs++;
        if (oif.out_vld === 1'b1) vld_cycles++;
        if (oif.out_vld === 1'b1 && out_rdy) begin
            hs_ch.push_back(int'(oif.out_ch));
            hs_fr.push_back(oif.out_frame);
            hs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [FW-1:0] act,
                       input logic [FW-1:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_3wi);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic strobe(input int ch, input logic [FW-1:0] d);
        frame_in[ch*FW +: FW] = d;
        frame_vld[ch] = 1'b1;
        step();
        frame_vld = '0;
    endtask

    task automatic do_reset();
        rst_3wi = 1'b1;
        step();
        rst_3wi = 1'b0;
        hs_ch.delete();
        hs_fr.delete();
        hs_cyc.delete();
    endtask

    localparam logic [FW-1:0] F_ABCD = 70'h3_0000_0000_0000_ABCD;
    localparam logic [FW-1:0] F_A = 70'h1_1111_0000_0000_000A;
    localparam logic [FW-1:0] F_B = 70'h2_2222_0000_0000_000B;
    localparam logic [FW-1:0] F_C = 70'h3_3333_0000_0000_000C;

    initial begin
        int v0;
        rst_3wi   = 1'b1;
        frame_in  = '1;
        frame_vld = '1;
        ovf_clr   = '0;
        out_rdy   = 1'b1;
        steps(2);
        @(negedge clk_3wi);
        chk("rst_out_vld", FW'(oif.out_vld), '0);
        chk("rst_out_frame", oif.out_frame, '0);
        chk("rst_out_ch", FW'(oif.out_ch), '0);
        chk("rst_mirror_or", FW'(|rdat_mirror), '0);
        chk("rst_ovf", FW'(ovf_sticky), '0);
        step();
        rst_3wi   = 1'b0;
        frame_vld = '0;
        v0 = vld_cycles;
        steps(3);
        @(negedge clk_3wi);
        chk("post_rst_no_vld", FW'(vld_cycles - v0), '0);

        strobe(2, F_ABCD);
        @(negedge clk_3wi);
        chk("single_mirror2", rdat_mirror[2*FW +: FW], F_ABCD);
        chk("single_vld_early", FW'(oif.out_vld), '0);
        step();
        @(negedge clk_3wi);
        chk("single_vld", FW'(oif.out_vld), 70'd1);
        chk("single_ch", FW'(oif.out_ch), 70'd2);
        chk("single_frame", oif.out_frame, F_ABCD);
        steps(3);

        do_reset();
        for (int i = 0; i < CH; i++) frame_in[i*FW +: FW] = FW'(70'h100 + i);
        frame_vld = '1;
        step();
        frame_vld = '0;
        steps(20);
        chk("rr_count", FW'(hs_ch.size()), 70'd8);
        for (int i = 0; i < hs_ch.size(); i++) begin
            chk("rr_order", FW'(hs_ch[i]), FW'(i));
            chk("rr_frame", hs_fr[i], FW'(70'h100 + i));
            if (i > 0) chk("rr_spacing", FW'(hs_cyc[i] - hs_cyc[i-1]), 70'd2);
        end

        do_reset();
        out_rdy = 1'b0;
        strobe(5, F_A);
        step();
        strobe(5, F_B);
        strobe(5, F_C);
        @(negedge clk_3wi);
        chk("bp_hold_frame", oif.out_frame, F_A);
        chk("bp_ovf5", FW'(ovf_sticky[5]), 70'd1);
        chk("bp_mirror5", rdat_mirror[5*FW +: FW], F_C);
        step();
        out_rdy = 1'b1;
        steps(6);
        chk("bp_accepts", FW'(hs_fr.size()), 70'd2);
        if (hs_fr.size() >= 2) begin
            chk("bp_first", hs_fr[0], F_A);
            chk("bp_second", hs_fr[1], F_C);
        end
        ovf_clr[5] = 1'b1;
        step();
        ovf_clr = '0;
        @(negedge clk_3wi);
        chk("ovf_clr5", FW'(ovf_sticky[5]), '0);

        do_reset();
        out_rdy = 1'b0;
        strobe(0, F_A);
        step();
        strobe(1, F_B);
        frame_in[1*FW +: FW] = F_C;
        frame_vld[1] = 1'b1;
        ovf_clr[1] = 1'b1;
        step();
        frame_vld = '0;
        ovf_clr = '0;
        @(negedge clk_3wi);
        chk("set_wins_ovf1", FW'(ovf_sticky[1]), 70'd1);
        step();
        out_rdy = 1'b1;
        steps(8);

        do_reset();
        out_rdy = 1'b1;
        for (int n = 0; n < 3; n++) begin
            strobe(0, 70'h5);
            steps(3);
        end
`ifdef RDAT_CHANGE_ONLY_EN
        chk("chg_three_same", FW'(hs_ch.size()), 70'd1);
`else
        chk("chg_three_same", FW'(hs_ch.size()), 70'd3);
`endif
        strobe(0, 70'h6);
        steps(3);
`ifdef RDAT_CHANGE_ONLY_EN
        chk("chg_after_new", FW'(hs_ch.size()), 70'd2);
`else
        chk("chg_after_new", FW'(hs_ch.size()), 70'd4);
`endif

        out_rdy = 1'b0;
        strobe(3, F_B);
        step();
        rst_3wi = 1'b1;
        step();
        rst_3wi = 1'b0;
        @(negedge clk_3wi);
        chk("midrst_vld", FW'(oif.out_vld), '0);
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
